regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file for the pipelined CPU. It generalises the single-cycle register heap in three ways: configurable data width, depth and read-port count; two write ports; and synchronous reset. It also adds a per-register busy scoreboard that issue logic uses for hazard detection. Register 0 is hard-wired to zero.

Parameters:
DW, 32, data width in bits.
AW, 5, address width; depth = 2**AW registers.
NRD, 2, number of read ports (1..4).

Ports:
WrClk  in  1  clock; all state updates on its rising edge.
Rst  in  1  synchronous reset, active-high.
Ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
busR  out  NRD*DW  read data; port i uses bits [i*DW +: DW].
BusyR  out  NRD  busy flag of the register addressed by each read port.
Rw0  in  AW  write port 0 address (older instruction).
RegWr0  in  1  write port 0 enable.
busW0  in  DW  write port 0 data.
Rw1  in  AW  write port 1 address (younger instruction).
RegWr1  in  1  write port 1 enable.
busW1  in  DW  write port 1 data.
SetBusy  in  1  issue strobe: mark register Rd busy.
Rd  in  AW  destination register being issued.

Behaviour:
- Storage: 2**AW x DW registers plus 2**AW busy bits.
- Reset (Rst high at an edge): all registers and all busy bits cleared to 0. While Rst is high, writes, SetBusy and bypass are all ignored.
- Reset value of outputs:
  - busR = 0 and BusyR = 0 from the first edge with Rst high.
  - Before the first reset, register contents are X and busy bits are undefined.
- Read: combinational, zero latency. busR[i] = regs[Ra[i]].
  - Address 0 always reads 0; BusyR for address 0 is always 0.
- Write: on a rising edge, port k writes busWk to regs[Rwk] if RegWrk=1 and Rwk != 0.
  - Write to address 0 is discarded.
- Write conflict: if both ports are enabled with Rw0 == Rw1 != 0, port 1 (younger) wins. Port 0's data is dropped.
- Busy clear: on an edge, busy[Rwk] is cleared for each enabled write port with Rwk != 0.
- Busy set: on an edge, busy[Rd] is set if SetBusy=1 and Rd != 0.
- Set/clear collision: SetBusy to the same register as an enabled write in the same cycle leaves busy = 1. Set wins, because the newly issued instruction owns the register.
- No counting: repeated SetBusy on an already-busy register keeps it at 1. A single writeback clears it.
- All read ports are independent. Any number of ports may address the same register.
- Depth wrap: addresses are exactly AW bits wide, so no out-of-range access exists.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding within the cycle.
  - If a read port's Ra matches an enabled write port address (non-zero), busR returns that write data, not the stored value. Port 1 takes priority over port 0.
  - BusyR for that read port is forced to 0 unless SetBusy targets the same register in the same cycle.
  - Forwarding is disabled while Rst is high.
- Undefined: reads return the stored value only. The new value is visible the cycle after the write edge.

Test Plan:
1. Rst=1 for 1 edge, then read all 32 addresses on both ports -> busR=0 and BusyR=0 everywhere.
2. Write port 0: Rw0=5, busW0=0xDEADBEEF, RegWr0=1 for one edge; then Ra0=5 -> busR0=0xDEADBEEF. Next, Rw0=0, busW0=0x1234 -> reading address 0 still gives 0.
3. Both ports: Rw0=Rw1=7, busW0=0x11, busW1=0x22, both enabled for one edge -> regs[7] reads 0x22.
4. Scoreboard:
   - SetBusy=1, Rd=9 -> next cycle BusyR=1 for Ra=9.
   - RegWr0=1, Rw0=9 with SetBusy=1, Rd=9 in the same edge -> busy stays 1.
   - A following write to 9 without SetBusy -> busy clears to 0.
5. Bypass:
   - With REGFILE_BYPASS_EN: Rw1=3, busW1=0xA5, RegWr1=1, Ra1=3 in the same cycle -> busR1=0xA5 before the edge.
   - Without it: busR1 shows the old value, and 0xA5 appears after the edge.
6. Reset mid-operation: write 0x55 to register 12 and set busy on register 4, then assert Rst together with RegWr0=1, Rw0=12 -> after the edge regs[12]=0 and busy[4]=0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
// master = issue/writeback side driving addresses and data; slave = register file.
interface regfile_mp_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic [NRD*AW-1:0] Ra;
  logic [NRD*DW-1:0] busR;
  logic [NRD-1:0]    BusyR;
  logic [AW-1:0]     Rw0;
  logic              RegWr0;
  logic [DW-1:0]     busW0;
  logic [AW-1:0]     Rw1;
  logic              RegWr1;
  logic [DW-1:0]     busW1;
  logic              SetBusy;
  logic [AW-1:0]     Rd;

  modport master (
    output Ra, Rw0, RegWr0, busW0, Rw1, RegWr1, busW1, SetBusy, Rd,
    input  busR, BusyR
  );

  modport slave (
    input  Ra, Rw0, RegWr0, busW0, Rw1, RegWr1, busW1, SetBusy, Rd,
    output busR, BusyR
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports,
// synchronous reset and a per-register busy scoreboard. Register 0 reads as zero.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding;
// when undefined, reads return only the stored value.
module regfile_mp #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input logic         WrClk,
  input logic         Rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0] busy_reg;

  // Port-level write qualifiers: writes to register 0 are discarded.
  logic wr0_en, wr1_en, set_en;
  assign wr0_en = bus.RegWr0 && (bus.Rw0 != '0);
  assign wr1_en = bus.RegWr1 && (bus.Rw1 != '0);
  assign set_en = bus.SetBusy && (bus.Rd != '0);

  // Register storage: port 1 is written last so it overrides port 0 on a conflict.
  always_ff @(posedge WrClk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
    end else begin
      if (wr0_en) regs_reg[bus.Rw0] <= bus.busW0;
      if (wr1_en) regs_reg[bus.Rw1] <= bus.busW1;
    end
  end

  // Busy scoreboard: writeback clears, issue sets; set is applied last so it wins.
  always_ff @(posedge WrClk) begin
    if (Rst) begin
      busy_reg <= '0;
    end else begin
      if (wr0_en) busy_reg[bus.Rw0] <= 1'b0;
      if (wr1_en) busy_reg[bus.Rw1] <= 1'b0;
      if (set_en) busy_reg[bus.Rd]  <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_busy;

    assign rd_addr = bus.Ra[gi*AW +: AW];

    // Combinational read with register 0 forced to zero and optional forwarding.
    always_comb begin
      rd_data = regs_reg[rd_addr];
      rd_busy = busy_reg[rd_addr];
      if (rd_addr == '0) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (!Rst) begin
        if (wr1_en && (bus.Rw1 == rd_addr)) begin
          rd_data = bus.busW1;
          rd_busy = set_en && (bus.Rd == rd_addr);
        end else if (wr0_en && (bus.Rw0 == rd_addr)) begin
          rd_data = bus.busW0;
          rd_busy = set_en && (bus.Rd == rd_addr);
        end
      end
`endif
    end

    assign bus.busR[gi*DW +: DW] = rd_data;
    assign bus.BusyR[gi]         = rd_busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp; expected read results are queued
// when each read is set up and compared once the outputs have settled.
module tb_regfile_mp;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic WrClk = 1'b0;
  logic Rst;

  always #5 WrClk = ~WrClk;

  regfile_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .WrClk (WrClk),
    .Rst   (Rst),
    .bus   (bus.slave)
  );

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge WrClk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    bus.Ra[p*AW +: AW] = a;
  endtask

  task automatic expect_rd(input string tag, input int p, input logic [DW-1:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.port = p; e.data = d; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic idle_writes();
    bus.RegWr0 = 1'b0; bus.RegWr1 = 1'b0; bus.SetBusy = 1'b0;
  endtask

  task automatic check_all();
    exp_t e;
    logic [DW-1:0] obs_d;
    logic          obs_b;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs_d = bus.busR[e.port*DW +: DW];
      obs_b = bus.BusyR[e.port];
      vectors++;
      assert (obs_d === e.data) else begin
        miscompares++;
        $error("FAIL %s data port%0d observed=%h expected=%h", e.tag, e.port, obs_d, e.data);
      end
      vectors++;
      assert (obs_b === e.busy) else begin
        miscompares++;
        $error("FAIL %s busy port%0d observed=%b expected=%b", e.tag, e.port, obs_b, e.busy);
      end
      $display("check %s port%0d data=%h busy=%b", e.tag, e.port, obs_d, obs_b);
    end
  endtask

  initial begin
    Rst = 1'b1;
    bus.Ra = '0; bus.Rw0 = '0; bus.busW0 = '0; bus.Rw1 = '0; bus.busW1 = '0; bus.Rd = '0;
    idle_writes();

    // Reset, then every address reads zero and not busy on both ports.
    tick();
    Rst = 1'b0;
    for (int a = 0; a < 2**AW; a++) begin
      set_ra(0, AW'(a)); set_ra(1, AW'(a));
      expect_rd("reset_sweep", 0, '0, 1'b0);
      expect_rd("reset_sweep", 1, '0, 1'b0);
      check_all();
    end

    // Port 0 write, then a discarded write to register 0.
    bus.Rw0 = 5; bus.busW0 = 32'hDEADBEEF; bus.RegWr0 = 1'b1;
    tick(); idle_writes();
    set_ra(0, 5); expect_rd("wr0_r5", 0, 32'hDEADBEEF, 1'b0); check_all();
    bus.Rw0 = 0; bus.busW0 = 32'h1234; bus.RegWr0 = 1'b1;
    tick(); idle_writes();
    set_ra(0, 0); expect_rd("wr_r0_discard", 0, '0, 1'b0); check_all();

    // Same-address conflict: port 1 wins.
    bus.Rw0 = 7; bus.busW0 = 32'h11; bus.Rw1 = 7; bus.busW1 = 32'h22;
    bus.RegWr0 = 1'b1; bus.RegWr1 = 1'b1;
    tick(); idle_writes();
    set_ra(0, 7); set_ra(1, 7);
    expect_rd("conflict_p0", 0, 32'h22, 1'b0);
    expect_rd("conflict_p1", 1, 32'h22, 1'b0);
    check_all();

    // Top-of-range addresses on both ports simultaneously.
    bus.Rw0 = 31; bus.busW0 = 32'hAAAA5555; bus.Rw1 = 30; bus.busW1 = 32'hBBBB0000;
    bus.RegWr0 = 1'b1; bus.RegWr1 = 1'b1;
    tick(); idle_writes();
    set_ra(0, 31); set_ra(1, 30);
    expect_rd("dual_r31", 0, 32'hAAAA5555, 1'b0);
    expect_rd("dual_r30", 1, 32'hBBBB0000, 1'b0);
    check_all();

    // Scoreboard: set, set-vs-clear collision, plain writeback clear.
    bus.SetBusy = 1'b1; bus.Rd = 9;
    tick(); idle_writes();
    set_ra(0, 9); expect_rd("busy_set", 0, '0, 1'b1); check_all();
    bus.RegWr0 = 1'b1; bus.Rw0 = 9; bus.busW0 = 32'h99; bus.SetBusy = 1'b1; bus.Rd = 9;
    tick(); idle_writes();
    expect_rd("busy_set_wins", 0, 32'h99, 1'b1); check_all();
    bus.RegWr1 = 1'b1; bus.Rw1 = 9; bus.busW1 = 32'h9A;
    tick(); idle_writes();
    expect_rd("busy_clear", 0, 32'h9A, 1'b0); check_all();

    // Same-cycle read of a register being written by port 1.
    bus.Rw1 = 3; bus.busW1 = 32'hA5; bus.RegWr1 = 1'b1; set_ra(1, 3);
`ifdef REGFILE_BYPASS_EN
    expect_rd("bypass_pre", 1, 32'hA5, 1'b0);
`else
    expect_rd("bypass_pre", 1, 32'h0, 1'b0);
`endif
    check_all();
    tick(); idle_writes();
    expect_rd("bypass_post", 1, 32'hA5, 1'b0); check_all();

    // Reset in the middle of activity.
    bus.Rw0 = 12; bus.busW0 = 32'h55; bus.RegWr0 = 1'b1; bus.SetBusy = 1'b1; bus.Rd = 4;
    tick(); idle_writes();
    set_ra(0, 12); set_ra(1, 4);
    expect_rd("pre_rst_r12", 0, 32'h55, 1'b0);
    expect_rd("pre_rst_busy4", 1, '0, 1'b1);
    check_all();
    Rst = 1'b1; bus.RegWr0 = 1'b1; bus.Rw0 = 12; bus.busW0 = 32'h77;
    expect_rd("rst_no_bypass", 0, 32'h55, 1'b0); check_all();
    tick();
    Rst = 1'b0; idle_writes();
    expect_rd("post_rst_r12", 0, '0, 1'b0);
    expect_rd("post_rst_busy4", 1, '0, 1'b0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
